// File: rtl/dual_dac_attenuator.sv
// Serially loaded dual 8-bit DAC attenuator: scales and mixes a 16-bit stereo stream.
// Optional feature macro: ATTEN_CROSSMIX_EN enables the L->R / R->L cross-mix gains.
module dual_dac_attenuator (
    input  logic               clk30,
    input  logic               reset,
    input  logic               datadac,
    input  logic               clkdac,
    input  logic               csdac1n,
    input  logic               csdac2n,
    input  logic signed [15:0] audio_left_in,
    input  logic signed [15:0] audio_right_in,
    output logic signed [15:0] audio_left_out,
    output logic signed [15:0] audio_right_out
);

    localparam int unsigned DW = 16;
    localparam int unsigned GW = 8;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] FULL    = CW'(16);
    localparam logic [GW-1:0] UNITY   = 8'hFF;

    logic          clkdac_q;
    logic [1:0]    csn_q;
    logic [1:0]    csn_c;
    logic          clk_rise_c;
    logic [1:0]    cs_rise_c;
    logic [DW-1:0] sr_q  [2];
    logic [CW-1:0] cnt_q [2];
    logic [GW-1:0] g_ll_q, g_rr_q, g_rl_c, g_lr_c;

    assign csn_c      = {csdac2n, csdac1n};
    assign clk_rise_c = clkdac & ~clkdac_q;
    assign cs_rise_c  = csn_c & ~csn_q;

    // Edge-detect history for the serial clock and the chip selects.
    always_ff @(posedge clk30) begin
        if (reset) begin
            clkdac_q <= 1'b0;
            csn_q    <= 2'b11;
        end else begin
            clkdac_q <= clkdac;
            csn_q    <= csn_c;
        end
    end

    // Per-chip shift register and saturating bit counter.
    always_ff @(posedge clk30) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                sr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cs_rise_c[i]) begin
                    cnt_q[i] <= '0;
                end else if (!csn_c[i] && clk_rise_c) begin
                    sr_q[i] <= {sr_q[i][DW-2:0], datadac};
                    if (cnt_q[i] != FULL) cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Direct-path gains latch on select deassert only when a full frame was seen.
    always_ff @(posedge clk30) begin
        if (reset) begin
            g_ll_q <= UNITY;
            g_rr_q <= UNITY;
        end else begin
            if (cs_rise_c[0] && cnt_q[0] >= FULL) g_ll_q <= sr_q[0][DW-1:GW];
            if (cs_rise_c[1] && cnt_q[1] >= FULL) g_rr_q <= sr_q[1][DW-1:GW];
        end
    end

`ifdef ATTEN_CROSSMIX_EN
    logic [GW-1:0] g_rl_q, g_lr_q;

    always_ff @(posedge clk30) begin
        if (reset) begin
            g_rl_q <= '0;
            g_lr_q <= '0;
        end else begin
            if (cs_rise_c[0] && cnt_q[0] >= FULL) g_rl_q <= sr_q[0][GW-1:0];
            if (cs_rise_c[1] && cnt_q[1] >= FULL) g_lr_q <= sr_q[1][GW-1:0];
        end
    end

    assign g_rl_c = g_rl_q;
    assign g_lr_c = g_lr_q;
`else
    assign g_rl_c = '0;
    assign g_lr_c = '0;
`endif

    // Full-scale code passes the sample untouched; otherwise floor((s*g)/256).
    function automatic logic signed [15:0] scale(input logic signed [15:0] s,
                                                 input logic [7:0] g);
        logic signed [23:0] p;
        p = 24'(s) * 24'($signed({1'b0, g}));
        if (g == UNITY) return s;
        return $signed(p[23:8]);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7FFF;
        return $signed(v[15:0]);
    endfunction

    logic signed [15:0] s_ll_q, s_rl_q, s_rr_q, s_lr_q;
    logic signed [16:0] sum_l_c, sum_r_c;

    assign sum_l_c = 17'(s_ll_q) + 17'(s_rl_q);
    assign sum_r_c = 17'(s_rr_q) + 17'(s_lr_q);

    // Two-stage pipeline: scaled products, then saturated sums.
    always_ff @(posedge clk30) begin
        if (reset) begin
            s_ll_q          <= '0;
            s_rl_q          <= '0;
            s_rr_q          <= '0;
            s_lr_q          <= '0;
            audio_left_out  <= '0;
            audio_right_out <= '0;
        end else begin
            s_ll_q          <= scale(audio_left_in,  g_ll_q);
            s_rl_q          <= scale(audio_right_in, g_rl_c);
            s_rr_q          <= scale(audio_right_in, g_rr_q);
            s_lr_q          <= scale(audio_left_in,  g_lr_c);
            audio_left_out  <= sat16(sum_l_c);
            audio_right_out <= sat16(sum_r_c);
        end
    end

endmodule

// File: tb/tb_dual_dac_attenuator.sv
// Randomized self-checking bench for dual_dac_attenuator against an arithmetic reference model.
module tb_dual_dac_attenuator;

    logic               clk30 = 1'b0;
    logic               reset = 1'b1;
    logic               datadac = 1'b0;
    logic               clkdac = 1'b0;
    logic               csdac1n = 1'b1;
    logic               csdac2n = 1'b1;
    logic signed [15:0] audio_left_in = '0;
    logic signed [15:0] audio_right_in = '0;
    logic signed [15:0] audio_left_out;
    logic signed [15:0] audio_right_out;

    dual_dac_attenuator dut (
        .clk30          (clk30),
        .reset          (reset),
        .datadac        (datadac),
        .clkdac         (clkdac),
        .csdac1n        (csdac1n),
        .csdac2n        (csdac2n),
        .audio_left_in  (audio_left_in),
        .audio_right_in (audio_right_in),
        .audio_left_out (audio_left_out),
        .audio_right_out(audio_right_out)
    );

    always #5 clk30 = ~clk30;

`ifdef ATTEN_CROSSMIX_EN
    localparam bit CM = 1'b1;
`else
    localparam bit CM = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference gains
    int m_ll = 255, m_rr = 255, m_rl = 0, m_lr = 0;
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int m_scale(input int s, input int g);
        if (g == 255) return s;
        return (s * g) >>> 8;
    endfunction

    function automatic logic [15:0] m_mix(input int a, input int b);
        int sum;
        sum = a + b;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return 16'(sum);
    endfunction

    function automatic logic [15:0] model_l(input logic signed [15:0] l, input logic signed [15:0] r);
        return m_mix(m_scale(int'(l), m_ll), m_scale(int'(r), CM ? m_rl : 0));
    endfunction

    function automatic logic [15:0] model_r(input logic signed [15:0] l, input logic signed [15:0] r);
        return m_mix(m_scale(int'(r), m_rr), m_scale(int'(l), CM ? m_lr : 0));
    endfunction

    task automatic model_reset();
        m_ll = 255; m_rr = 255; m_rl = 0; m_lr = 0;
    endtask

    // One audio sample per cycle; outputs compared against the sample from two cycles earlier.
    task automatic audio_cycle(input logic signed [15:0] l, input logic signed [15:0] r);
        @(negedge clk30);
        if (exp_l.size() == 2) begin
            check("out_l", audio_left_out,  exp_l.pop_front());
            check("out_r", audio_right_out, exp_r.pop_front());
        end
        audio_left_in  = l;
        audio_right_in = r;
        exp_l.push_back(model_l(l, r));
        exp_r.push_back(model_r(l, r));
    endtask

    task automatic audio_run(input int n, input logic signed [15:0] l, input logic signed [15:0] r);
        for (int i = 0; i < n; i++) audio_cycle(l, r);
    endtask

    function automatic logic signed [15:0] rand_sample();
        case ($urandom_range(0, 5))
            0:       return 16'sh7FFF;
            1:       return 16'sh8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic audio_rand(input int n);
        for (int i = 0; i < n; i++) audio_cycle(rand_sample(), rand_sample());
    endtask

    // Bit-bang a frame MSB first; optional reset pulse before bit index rst_at.
    task automatic send_frame(input bit c1, input bit c2, input logic [31:0] data,
                              input int nbits, input int rst_at);
        bit          bits[$];
        logic [15:0] frame;
        exp_l.delete();
        exp_r.delete();
        @(negedge clk30);
        csdac1n = !c1;
        csdac2n = !c2;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk30);
                @(negedge clk30);
                reset = 1'b0;
                bits.delete();
                model_reset();
            end
            datadac = data[nbits-1-i];
            bits.push_back(datadac);
            @(negedge clk30);
            clkdac = 1'b1;
            @(negedge clk30);
            @(negedge clk30);
            clkdac = 1'b0;
            @(negedge clk30);
        end
        csdac1n = 1'b1;
        csdac2n = 1'b1;
        @(negedge clk30);
        @(negedge clk30);
        if (bits.size() >= 16) begin
            frame = '0;
            for (int j = bits.size() - 16; j < bits.size(); j++) frame = {frame[14:0], bits[j]};
            if (c1) begin m_ll = int'(frame[15:8]); m_rl = int'(frame[7:0]); end
            if (c2) begin m_rr = int'(frame[15:8]); m_lr = int'(frame[7:0]); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk30);
        check("rst_out_l", audio_left_out,  16'h0000);
        check("rst_out_r", audio_right_out, 16'h0000);
        reset = 1'b0;

        // Pass-through after reset
        audio_run(6, 16'sh1234, -16'sh1000);
        check("t1_pass_l", audio_left_out,  16'h1234);
        check("t1_pass_r", audio_right_out, 16'hF000);
        audio_rand(20);

        // Half gain on left
        send_frame(1'b1, 1'b0, 32'h8000, 16, -1);
        audio_run(5, 16'sh4000, 16'sh0123);
        check("t2_half_l", audio_left_out,  16'h2000);
        check("t2_keep_r", audio_right_out, 16'h0123);
        audio_rand(16);

        // Chip 2: gRR=0, gLR=full
        send_frame(1'b0, 1'b1, 32'h00FF, 16, -1);
        audio_run(5, 16'sh7FFF, 16'sh7FFF);
        check("t3_cross_r", audio_right_out, CM ? 16'h7FFF : 16'h0000);
        audio_rand(16);

        // Saturation on the left mix
        send_frame(1'b1, 1'b0, 32'hFFFF, 16, -1);
        audio_run(5, 16'sh7000, 16'sh7000);
        check("t4_sat_pos", audio_left_out, CM ? 16'h7FFF : 16'h7000);
        audio_run(5, -16'sh7000, -16'sh7000);
        check("t4_sat_neg", audio_left_out, CM ? 16'h8000 : 16'h9000);
        audio_rand(16);

        // Short frame discarded, long frame keeps last 16 bits
        send_frame(1'b1, 1'b0, 32'h0123, 12, -1);
        audio_rand(12);
        send_frame(1'b1, 1'b0, 32'hA5_4020, 20, -1);
        audio_run(5, 16'sh4000, 16'sh4000);
        check("t5_long_l", audio_left_out, CM ? 16'h1800 : 16'h1000);
        audio_rand(16);

        // Reset mid-frame: partial frame lost, remainder too short to latch
        send_frame(1'b0, 1'b1, 32'h1234, 16, 8);
        audio_run(5, 16'sh2222, -16'sh3333);
        check("t6_rst_l", audio_left_out,  16'h2222);
        check("t6_rst_r", audio_right_out, 16'hCCCD);
        audio_rand(12);

        // Random frames on either or both chips
        for (int k = 0; k < 10; k++) begin
            bit c1, c2;
            c1 = 1'($urandom);
            c2 = 1'($urandom);
            if (!c1 && !c2) c1 = 1'b1;
            send_frame(c1, c2, $urandom, int'($urandom_range(12, 20)), -1);
            audio_rand(24);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
